organ_mode_ctrl: RTL and testbench

ORGAN_MODE_CTRL -- requirements
Module: organ_mode_ctrl

---
 rtl/organ_mode_ctrl_if.sv | 42 ++++
 rtl/organ_mode_ctrl.sv | 177 +++++++++++++++++
 tb/tb_organ_mode_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/organ_mode_ctrl_if.sv
// Bus between the organ mode controller and its surroundings.
// Groups the key/control pulses, the song ROM port and the controller's
// outputs to the tone generator and the remap unit.
//   pose_buts[7:0]  key-press pulses (bit i = key i)
//   pose_esc        escape pulse
//   pose_mode       mode-button pulse
//   setting_done    remap unit finished (8th key assigned)
//   beat_tick       tempo pulse
//   song_data[7:0]  song ROM word {note[2:0], rest, duration[3:0]}
//   play_buts[7:0]  key pulses to the tone generator
//   set_buts[7:0]   key pulses to the remap unit
//   set_esc         abort pulse to the remap unit
//   song_addr[5:0]  song ROM address
//   note_out[2:0]   autoplay note index
//   note_en         autoplay note sounding
//   mode[1:0]       0 FREE, 1 SETTING, 2 PLAY, 3 PAUSE
// The slave modport is the controller; master is whatever drives it.
interface organ_mode_ctrl_if;
  logic [7:0] pose_buts;
  logic       pose_esc;
  logic       pose_mode;
  logic       setting_done;
  logic       beat_tick;
  logic [7:0] song_data;
  logic [7:0] play_buts;
  logic [7:0] set_buts;
  logic       set_esc;
  logic [5:0] song_addr;
  logic [2:0] note_out;
  logic       note_en;
  logic [1:0] mode;

  modport master (
    output pose_buts, pose_esc, pose_mode, setting_done, beat_tick, song_data,
    input  play_buts, set_buts, set_esc, song_addr, note_out, note_en, mode
  );

  modport slave (
    input  pose_buts, pose_esc, pose_mode, setting_done, beat_tick, song_data,
    output play_buts, set_buts, set_esc, song_addr, note_out, note_en, mode
  );
endinterface

// File: rtl/organ_mode_ctrl.sv
// Organ mode controller: routes key pulses to the tone generator (FREE) or
// the key remap unit (SETTING), and plays a song from a synchronous ROM
// (PLAY/PAUSE). All outputs are registered.
// Ports:
//   slow_clk  system clock, rising edge
//   rst       synchronous active-high reset
//   bus       organ_mode_ctrl_if.slave (pulses in, ROM port, outputs)
module organ_mode_ctrl (
  input  logic              slow_clk,
  input  logic              rst,
  organ_mode_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {FREE = 2'd0, SETTING = 2'd1, PLAY = 2'd2, PAUSE = 2'd3} state_t;
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} sub_t;

  state_t     state_reg, state_next;
  sub_t       sub_reg, sub_next;
  logic       wait_reg, wait_next;        // FETCH: ROM word not yet valid
  logic [5:0] addr_reg, addr_next;
  logic [3:0] dur_cnt_reg, dur_cnt_next;
  logic [2:0] note_reg, note_next;
  logic       rest_reg, rest_next;        // remembered so PAUSE can restore note_en
  logic       note_en_reg, note_en_next;
  logic [7:0] play_buts_reg, play_buts_next;
  logic [7:0] set_buts_reg, set_buts_next;
  logic       set_esc_reg, set_esc_next;
  logic       stop_play;

  logic       ctrl_pulse;
  logic [2:0] rom_note;
  logic       rom_rest;
  logic [3:0] rom_dur;

  // A cycle carrying any higher-priority control pulse swallows key pulses.
  assign ctrl_pulse = bus.pose_esc | bus.pose_mode | bus.setting_done;
  assign rom_note   = bus.song_data[7:5];
  assign rom_rest   = bus.song_data[4];
  assign rom_dur    = bus.song_data[3:0];

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state_reg     <= FREE;
      sub_reg       <= FETCH;
      wait_reg      <= 1'b0;
      addr_reg      <= '0;
      dur_cnt_reg   <= '0;
      note_reg      <= '0;
      rest_reg      <= 1'b0;
      note_en_reg   <= 1'b0;
      play_buts_reg <= '0;
      set_buts_reg  <= '0;
      set_esc_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sub_reg       <= sub_next;
      wait_reg      <= wait_next;
      addr_reg      <= addr_next;
      dur_cnt_reg   <= dur_cnt_next;
      note_reg      <= note_next;
      rest_reg      <= rest_next;
      note_en_reg   <= note_en_next;
      play_buts_reg <= play_buts_next;
      set_buts_reg  <= set_buts_next;
      set_esc_reg   <= set_esc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sub_next       = sub_reg;
    wait_next      = wait_reg;
    addr_next      = addr_reg;
    dur_cnt_next   = dur_cnt_reg;
    note_next      = note_reg;
    rest_next      = rest_reg;
    note_en_next   = note_en_reg;
    play_buts_next = '0;
    set_buts_next  = '0;
    set_esc_next   = 1'b0;
    stop_play      = 1'b0;

    case (state_reg)
      FREE: begin
        if (bus.pose_mode && !bus.pose_esc) begin
          state_next = SETTING;
        end else if (!ctrl_pulse) begin
          play_buts_next = bus.pose_buts;
        end
      end
      SETTING: begin
        if (bus.pose_esc) begin
          state_next   = FREE;
          set_esc_next = 1'b1;
        end else if (bus.pose_mode) begin
          // Remap is aborted when leaving for PLAY; song starts at word 0.
          state_next   = PLAY;
          set_esc_next = 1'b1;
          sub_next     = FETCH;
          wait_next    = 1'b1;
          addr_next    = '0;
          dur_cnt_next = '0;
          note_en_next = 1'b0;
        end else if (bus.setting_done) begin
          state_next = FREE;
        end else if ($onehot(bus.pose_buts)) begin
          set_buts_next = bus.pose_buts;
        end
      end
      PLAY: begin
        if (bus.pose_esc) begin
          stop_play = 1'b1;
        end else if (bus.pose_mode) begin
          state_next   = PAUSE;
          note_en_next = 1'b0;
        end else if (sub_reg == FETCH) begin
          // First FETCH cycle lets the ROM register the address; the word
          // is sampled on the second.
          if (wait_reg) begin
            wait_next = 1'b0;
          end else if (rom_dur == 4'd0) begin
            stop_play = 1'b1;
          end else begin
            dur_cnt_next = rom_dur;
            note_next    = rom_note;
            rest_next    = rom_rest;
            note_en_next = ~rom_rest;
            sub_next     = HOLD;
          end
        end else if (bus.beat_tick) begin
          if (dur_cnt_reg == 4'd1) begin
            dur_cnt_next = '0;
            note_en_next = 1'b0;
            if (addr_reg == 6'd63) begin
              stop_play = 1'b1;
            end else begin
              addr_next = addr_reg + 6'd1;
              sub_next  = FETCH;
              wait_next = 1'b1;
            end
          end else begin
            dur_cnt_next = dur_cnt_reg - 4'd1;
          end
        end
      end
      PAUSE: begin
        if (bus.pose_esc) begin
          stop_play = 1'b1;
        end else if (bus.pose_mode) begin
          state_next   = PLAY;
          note_en_next = (sub_reg == HOLD) && !rest_reg;
        end
      end
      default: stop_play = 1'b1;
    endcase

    // Leaving playback returns every playback register to idle together
    // with the mode change.
    if (stop_play) begin
      state_next   = FREE;
      sub_next     = FETCH;
      wait_next    = 1'b0;
      addr_next    = '0;
      dur_cnt_next = '0;
      note_next    = '0;
      rest_next    = 1'b0;
      note_en_next = 1'b0;
    end
  end

  assign bus.mode      = state_reg;
  assign bus.play_buts = play_buts_reg;
  assign bus.set_buts  = set_buts_reg;
  assign bus.set_esc   = set_esc_reg;
  assign bus.song_addr = addr_reg;
  assign bus.note_out  = note_reg;
  assign bus.note_en   = note_en_reg;
endmodule

// File: tb/tb_organ_mode_ctrl.sv
// Testbench for organ_mode_ctrl: directed scenarios with literal
// expectations plus randomized pulses, checked every cycle against a
// behavioural song-player model.
module tb_organ_mode_ctrl;
  logic slow_clk = 1'b0;
  logic rst = 1'b0;
  organ_mode_ctrl_if bus ();

  organ_mode_ctrl dut (.slow_clk(slow_clk), .rst(rst), .bus(bus));

  always #5 slow_clk = ~slow_clk;

  // Synchronous song ROM: word appears one cycle after its address.
  logic [7:0] rom [64];
  always @(posedge slow_clk) bus.song_data <= rom[bus.song_addr];

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] e_mode;
  logic [7:0] e_play, e_set;
  logic       e_esc, e_en;
  logic [2:0] e_note;
  int         e_addr;
  bit         m_holding, m_rest;
  int         m_fcnt, m_left;

  task automatic end_song();
    e_mode = 2'd0; e_addr = 0; e_note = 3'd0; e_en = 1'b0;
    m_holding = 1'b0; m_rest = 1'b0; m_fcnt = 0; m_left = 0;
  endtask

  task automatic start_song();
    e_mode = 2'd2; e_addr = 0; e_en = 1'b0;
    m_holding = 1'b0; m_fcnt = 0; m_left = 0;
  endtask

  task automatic advance_song();
    logic [7:0] w;
    if (!m_holding) begin
      m_fcnt++;
      if (m_fcnt == 2) begin
        w = rom[e_addr];
        if (w[3:0] == 4'd0) end_song();
        else begin
          m_left = int'(w[3:0]); e_note = w[7:5]; m_rest = w[4];
          e_en = !w[4]; m_holding = 1'b1;
        end
      end
    end else if (bus.beat_tick) begin
      m_left--;
      if (m_left == 0) begin
        e_en = 1'b0; m_holding = 1'b0; m_fcnt = 0;
        if (e_addr == 63) end_song();
        else e_addr++;
      end
    end
  endtask

  always @(posedge slow_clk) begin
    e_play = 8'h00; e_set = 8'h00; e_esc = 1'b0;
    if (rst) begin
      end_song();
    end else begin
      case (e_mode)
        2'd0: begin
          if (bus.pose_mode && !bus.pose_esc) e_mode = 2'd1;
          else if (!(bus.pose_esc || bus.pose_mode || bus.setting_done)) e_play = bus.pose_buts;
        end
        2'd1: begin
          if (bus.pose_esc) begin e_esc = 1'b1; e_mode = 2'd0; end
          else if (bus.pose_mode) begin e_esc = 1'b1; start_song(); end
          else if (bus.setting_done) e_mode = 2'd0;
          else if ($countones(bus.pose_buts) == 1) e_set = bus.pose_buts;
        end
        2'd2: begin
          if (bus.pose_esc) end_song();
          else if (bus.pose_mode) begin e_mode = 2'd3; e_en = 1'b0; end
          else advance_song();
        end
        default: begin
          if (bus.pose_esc) end_song();
          else if (bus.pose_mode) begin e_mode = 2'd2; e_en = m_holding && !m_rest; end
        end
      endcase
    end
  end

  // Single compare process: outputs checked on every falling edge.
  always @(negedge slow_clk) begin
    if (chk_en) begin
      chk("mode", 32'(bus.mode), 32'(e_mode));
      chk("play_buts", 32'(bus.play_buts), 32'(e_play));
      chk("set_buts", 32'(bus.set_buts), 32'(e_set));
      chk("set_esc", 32'(bus.set_esc), 32'(e_esc));
      chk("song_addr", 32'(bus.song_addr), 32'(e_addr));
      chk("note_out", 32'(bus.note_out), 32'(e_note));
      chk("note_en", 32'(bus.note_en), 32'(e_en));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [7:0] b, input logic e, input logic m,
                      input logic d, input logic t, input logic r);
    @(negedge slow_clk);
    bus.pose_buts = b; bus.pose_esc = e; bus.pose_mode = m;
    bus.setting_done = d; bus.beat_tick = t; rst = r;
    @(posedge slow_clk);
    #1;
    bus.pose_buts = 8'h00; bus.pose_esc = 1'b0; bus.pose_mode = 1'b0;
    bus.setting_done = 1'b0; bus.beat_tick = 1'b0; rst = 1'b0;
  endtask

  task automatic idle();      step(8'h00, 0, 0, 0, 0, 0); endtask
  task automatic tick();      step(8'h00, 0, 0, 0, 1, 0); endtask
  task automatic press_mode(); step(8'h00, 0, 1, 0, 0, 0); endtask
  task automatic do_reset();  step(8'h00, 0, 0, 0, 0, 1); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    bus.pose_buts = 8'h00; bus.pose_esc = 1'b0; bus.pose_mode = 1'b0;
    bus.setting_done = 1'b0; bus.beat_tick = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    do_reset();
    do_reset();
    chk_en = 1'b1;

    // Reset state
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_addr", 32'(bus.song_addr), 32'd0);
    chk("rst_note_en", 32'(bus.note_en), 32'd0);

    // FREE forwarding
    for (int i = 0; i < 3; i++) begin
      pat = 8'h01 << i;
      step(pat, 0, 0, 0, 0, 0);
      chk("free_play_buts", 32'(bus.play_buts), 32'(pat));
      chk("free_set_buts", 32'(bus.set_buts), 32'd0);
    end

    // SETTING: one-hot filter, setting_done exits without abort
    press_mode();
    chk("setting_mode", 32'(bus.mode), 32'd1);
    step(8'h08, 0, 0, 0, 0, 0);
    chk("set_onehot", 32'(bus.set_buts), 32'h08);
    step(8'h03, 0, 0, 0, 0, 0);
    chk("set_multi", 32'(bus.set_buts), 32'h00);
    step(8'h00, 0, 0, 1, 0, 0);
    chk("done_mode", 32'(bus.mode), 32'd0);
    chk("done_no_esc", 32'(bus.set_esc), 32'd0);

    // SETTING: escape beats mode in the same cycle
    press_mode();
    step(8'h00, 1, 1, 0, 0, 0);
    chk("esc_mode", 32'(bus.mode), 32'd0);
    chk("esc_pulse", 32'(bus.set_esc), 32'd1);
    idle();
    chk("esc_pulse_end", 32'(bus.set_esc), 32'd0);

    // PLAY: {note5,dur2}, {rest,dur1}, {end}
    rom[0] = {3'd5, 1'b0, 4'd2};
    rom[1] = {3'd0, 1'b1, 4'd1};
    rom[2] = 8'h00;
    press_mode();
    press_mode();
    chk("play_mode", 32'(bus.mode), 32'd2);
    chk("play_abort", 32'(bus.set_esc), 32'd1);
    idle();
    idle();
    chk("note5", 32'(bus.note_out), 32'd5);
    chk("note5_en", 32'(bus.note_en), 32'd1);
    tick();
    chk("note5_beat1", 32'(bus.note_en), 32'd1);
    tick();
    chk("note5_off", 32'(bus.note_en), 32'd0);
    chk("addr1", 32'(bus.song_addr), 32'd1);
    tick();   // ignored while fetching
    idle();
    chk("rest_en", 32'(bus.note_en), 32'd0);
    tick();
    chk("addr2", 32'(bus.song_addr), 32'd2);
    idle();
    idle();
    chk("song_end_mode", 32'(bus.mode), 32'd0);

    // Pause mid-note keeps the remaining duration
    rom[0] = {3'd3, 1'b0, 4'd5};
    rom[1] = {3'd2, 1'b0, 4'd3};
    press_mode();
    press_mode();
    idle();
    idle();
    tick();
    press_mode();
    chk("pause_mode", 32'(bus.mode), 32'd3);
    chk("pause_en", 32'(bus.note_en), 32'd0);
    repeat (3) tick();
    chk("pause_addr", 32'(bus.song_addr), 32'd0);
    press_mode();
    chk("resume_en", 32'(bus.note_en), 32'd1);
    repeat (3) tick();
    chk("resume_held", 32'(bus.note_en), 32'd1);
    tick();
    chk("resume_off", 32'(bus.note_en), 32'd0);
    chk("resume_addr", 32'(bus.song_addr), 32'd1);
    idle();
    idle();
    chk("hold2_en", 32'(bus.note_en), 32'd1);
    do_reset();
    chk("hold_rst_mode", 32'(bus.mode), 32'd0);
    chk("hold_rst_note", 32'(bus.note_out), 32'd0);
    chk("hold_rst_en", 32'(bus.note_en), 32'd0);

    // Last ROM word ends playback instead of wrapping
    for (int i = 0; i < 64; i++) rom[i] = {3'd1, 1'b0, 4'd1};
    press_mode();
    press_mode();
    for (int k = 0; k < 64; k++) begin
      idle();
      idle();
      if (k == 63) chk("addr63", 32'(bus.song_addr), 32'd63);
      tick();
    end
    chk("wrap_mode", 32'(bus.mode), 32'd0);
    chk("wrap_addr", 32'(bus.song_addr), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 64; i++) begin
      rom[i] = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                4'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 3))};
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] b;
      int p;
      p = $urandom_range(0, 99);
      b = (p < 15) ? 8'(1 << $urandom_range(0, 7)) : (p < 30) ? 8'($urandom) : 8'h00;
      step(b, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35,
           $urandom_range(0, 999) < 3);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
